pes_sipo_deframer: RTL and testbench
====================================

// Module: pes_sipo_deframer
// PURPOSE
//  Serial-in/parallel-out frame receiver sitting directly downstream of the SISO shift register.
//  - Consumes serial_out of the SISO: one bit per clk, idle-high line, no oversampling.
//  - Strips start/parity/stop framing.
//  - Presents each received word on a valid/ready output with a one-entry holding register.
//  - Flags parity, framing and overrun errors.
// PARAMETERS
//  DATA_W     8  data bits per frame, sent LSB first
//  PARITY_EN  1  1: frame carries a parity bit after the data bits; 0: no parity bit
//  PARITY_ODD 0  0: even parity (ones in data+parity even); 1: odd parity
//  IDLE_MIN   4  consecutive 1s on serial_in required to arm the receiver after reset or a framing error
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-low reset
//  serial_in  in   1       serial line, idle level 1
//  data_out   out  DATA_W  received word, valid while data_valid=1
//  data_valid out  1       holding register full
//  data_ready in   1       consumer accepts the word when data_valid&&data_ready at a clk edge
//  parity_err out  1       parity mismatch for the word in data_out; qualified by data_valid
//  frame_err  out  1       1-cycle pulse: stop bit sampled as 0
//  overrun    out  1       1-cycle pulse: good frame completed while holding register full and not draining
//  busy       out  1       1 while in DATA, PARITY or STOP state
// BEHAVIOUR
//  - reset=0 (async): all outputs 0, FSM->ARM, idle counter 0, partial frame discarded.
//  - FSM states: ARM, IDLE, DATA, PARITY, STOP.
//  - ARM: count consecutive serial_in=1; any 0 clears the count.
//    - count reaches IDLE_MIN -> IDLE. Protects against the all-zero line the SISO drives after reset.
//  - IDLE: serial_in=0 sampled at edge S is the start bit -> DATA.
//  - DATA: bits sampled at edges S+1..S+DATA_W, bit i into data[i].
//    - then PARITY if PARITY_EN=1, else STOP.
//  - PARITY: one bit sampled at edge S+DATA_W+1.
//  - STOP: sampled at edge S+DATA_W+1+PARITY_EN.
//    - 1 (good frame) -> IDLE. Back-to-back frames allowed: the next start bit may be sampled on the very next edge.
//    - 0 -> frame_err pulse for one cycle, word discarded, FSM->ARM.
//  - Good frame load: on the same edge that samples the stop bit, when the holding register is empty or drains
//    on that edge (data_valid&&data_ready):
//    - data_out loads the word; data_valid=1 from that edge.
//    - parity_err loads (expected parity != received); always 0 when PARITY_EN=0.
//  - Good frame while holding register full and data_ready=0:
//    - overrun pulses one cycle; new word dropped.
//    - held word, data_out and parity_err unchanged.
//  - Handshake:
//    - data_valid, once set, stays set and data_out stays stable until accepted.
//    - Accept with no simultaneous load -> data_valid=0 next cycle; data_out retains its last value.
//  - Latency: data_valid rises at edge S+DATA_W+1+PARITY_EN (edge S+10 at defaults).
//  - Bit/frame counter: clog2(DATA_W+1) bits, cleared on entry to DATA; no wrap within a frame.
//  - frame_err and overrun never assert in the same cycle; both are 0 outside their pulse cycle.
// TESTING
//  1. Reset release, serial_in=1 for 4 cycles, frame 0xA5 (0,1,0,1,0,0,1,0,1,par 0,stop 1), data_ready=1
//     -> data_valid for exactly 1 cycle at S+10, data_out=0xA5, parity_err=0.
//  2. Line 0 for 10 cycles after reset, then 1,1,1,0
//     -> no busy, no data_valid (never armed); 4 ones then a frame for 0x3C -> 0x3C received.
//  3. Frame 0x01 with parity bit 0 (even parity expects 1) -> data_out=0x01, data_valid=1, parity_err=1.
//  4. Frame 0x5A with stop bit 0 -> frame_err 1-cycle pulse, no data_valid;
//     next 0x5A sent without 4 idle ones is ignored; sent after 4 ones it is received.
//  5. data_ready=0, back-to-back frames 0x11 then 0x22
//     -> data_out=0x11 held, overrun pulse at 0x22's stop edge; data_ready=1 -> 0x11 accepted, data_valid=0.
//  6. Assert reset midway through DATA of 0x77
//     -> all outputs 0 immediately, no word delivered, receiver requires 4 idle ones before the next frame.

Source files
------------

// File: rtl/pes_sipo_deframer.sv
// Serial-in/parallel-out frame receiver: strips start/parity/stop framing from an idle-high
// line and presents each word on a valid/ready port backed by a one-entry holding register.
module pes_sipo_deframer #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned IDLE_MIN   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned IDL_W = $clog2(IDLE_MIN + 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [IDL_W-1:0]   r_idle_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_par;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_perr;
    logic               r_frame_err;
    logic               r_overrun;

    logic w_bit_last;
    logic w_idle_done;
    logic w_stop_edge;
    logic w_good;
    logic w_load;
    logic w_par_exp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_ARM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_last  = (r_bit_cnt == CNT_W'(DATA_W - 1));
        w_idle_done = (r_idle_cnt == IDL_W'(IDLE_MIN - 1));
        w_stop_edge = (r_state == S_STOP);
        w_good      = w_stop_edge && serial_in;
        // A full register that drains on this same edge can take the new word.
        w_load      = w_good && (!r_valid || data_ready);
        w_par_exp   = (^r_shift) ^ PARITY_ODD;
        case (r_state)
            S_ARM:    if (serial_in && w_idle_done) w_state_nxt = S_IDLE;
            S_IDLE:   if (!serial_in) w_state_nxt = S_DATA;
            S_DATA:   if (w_bit_last) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP:   w_state_nxt = serial_in ? S_IDLE : S_ARM;
            default:  w_state_nxt = S_ARM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            if (r_state == S_ARM && serial_in && !w_idle_done)
                r_idle_cnt <= r_idle_cnt + IDL_W'(1);
            else
                r_idle_cnt <= '0;

            if (r_state == S_DATA) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_shift   <= {serial_in, r_shift[DATA_W-1:1]};
            end else begin
                r_bit_cnt <= '0;
            end

            if (r_state == S_PARITY)
                r_par <= serial_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_perr      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_edge && !serial_in;
            r_overrun   <= w_good && !w_load;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_perr  <= PARITY_EN && (r_par != w_par_exp);
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);

endmodule

// File: tb/tb_pes_sipo_deframer.sv
// Directed bench for pes_sipo_deframer at default parameters (8 data bits, even parity, 4 idle ones).
module tb_pes_sipo_deframer;
    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pes_sipo_deframer #(
        .DATA_W    (8),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0),
        .IDLE_MIN  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one line bit, let the DUT sample it, then observe 1 time unit after the edge.
    task automatic tick(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ones(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b1);
    endtask

    // Start bit, 8 data bits LSB first, parity bit, stop bit; returns just after the stop edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic exp_busy);
        tick(1'b0);
        check_eq("busy_after_start", busy, exp_busy);
        for (int i = 0; i < 8; i++) tick(d[i]);
        tick(p);
        tick(s);
    endtask

    initial begin
        reset      = 1'b0;
        serial_in  = 1'b1;
        data_ready = 1'b1;
        tick(1'b1);
        tick(1'b1);
        check_eq("rst_valid", data_valid, 0);
        check_eq("rst_data",  data_out,   0);
        check_eq("rst_busy",  busy,       0);
        check_eq("rst_ferr",  frame_err,  0);
        check_eq("rst_ovr",   overrun,    0);
        check_eq("rst_perr",  parity_err, 0);
        reset = 1'b1;

        // Test 1: arm, receive 0xA5 with correct even parity, single-cycle valid
        idle_ones(4);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        check_eq("t1_valid", data_valid, 1);
        check_eq("t1_data",  data_out,   8'hA5);
        check_eq("t1_perr",  parity_err, 0);
        tick(1'b1);
        check_eq("t1_valid_drop", data_valid, 0);
        check_eq("t1_busy_idle",  busy,       0);

        // Test 3: 0x01 with parity bit 0 (even parity expects 1)
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        check_eq("t3_valid", data_valid, 1);
        check_eq("t3_data",  data_out,   8'h01);
        check_eq("t3_perr",  parity_err, 1);
        tick(1'b1);
        check_eq("t3_valid_drop", data_valid, 0);

        // Test 4: stop bit 0 -> frame error, re-arm required
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check_eq("t4_ferr",  frame_err,  1);
        check_eq("t4_valid", data_valid, 0);
        check_eq("t4_busy",  busy,       0);
        tick(1'b0);
        check_eq("t4_ferr_pulse", frame_err, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_eq("t4_ignored_valid", data_valid, 0);
        idle_ones(4);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check_eq("t4_valid", data_valid, 1);
        check_eq("t4_data",  data_out,   8'h5A);
        check_eq("t4_perr",  parity_err, 0);
        tick(1'b1);

        // Test 5: no draining, back-to-back 0x11 then 0x22 -> overrun
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1);
        check_eq("t5_valid1", data_valid, 1);
        check_eq("t5_data1",  data_out,   8'h11);
        check_eq("t5_ovr0",   overrun,    0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        check_eq("t5_ovr",       overrun,    1);
        check_eq("t5_ferr_excl", frame_err,  0);
        check_eq("t5_data_held", data_out,   8'h11);
        check_eq("t5_valid_held", data_valid, 1);
        tick(1'b1);
        check_eq("t5_ovr_pulse", overrun,    0);
        check_eq("t5_still_valid", data_valid, 1);
        data_ready = 1'b1;
        tick(1'b1);
        check_eq("t5_accepted", data_valid, 0);
        check_eq("t5_data_keep", data_out,  8'h11);

        // Test 2: all-zero line after reset never arms
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0);
        check_eq("t2_busy_zero",  busy,       0);
        check_eq("t2_valid_zero", data_valid, 0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check_eq("t2_busy_partial", busy, 0);
        idle_ones(4);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        check_eq("t2_valid", data_valid, 1);
        check_eq("t2_data",  data_out,   8'h3C);
        check_eq("t2_perr",  parity_err, 0);
        tick(1'b1);

        // Test 6: async reset midway through DATA with a word held
        data_ready = 1'b0;
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1);
        check_eq("t6_held", data_valid, 1);
        tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        check_eq("t6_busy_mid", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_valid", data_valid, 0);
        check_eq("t6_rst_data",  data_out,   0);
        check_eq("t6_rst_busy",  busy,       0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        data_ready = 1'b1;
        send_frame(8'h77, 1'b0, 1'b1, 1'b0);
        check_eq("t6_unarmed_valid", data_valid, 0);
        idle_ones(4);
        send_frame(8'h77, 1'b0, 1'b1, 1'b1);
        check_eq("t6_valid", data_valid, 1);
        check_eq("t6_data",  data_out,   8'h77);
        check_eq("t6_perr",  parity_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
